// File: rtl/wallace_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wallace_pkg
// Description : Shared constants and elaboration-time helpers for the
//               pipelined Wallace-tree multiplier (product width, CSA tree
//               shape, operand mode encoding).
// Revision    : 1.0 - initial pipelined, parametrised release
// ============================================================================
package wallace_pkg;

   // Operand mode encoding carried with each operation
   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   // Full product width for a given operand width
   function automatic int prod_width(input int width);
      return 2 * width;
   endfunction

   // Number of rows still present before CSA level 'level' (level 0 = partial products)
   function automatic int csa_rows(input int width, input int level);
      int r;
      r = width;
      for (int l = 0; l < level; l++) begin
         r = 2 * (r / 3) + (r % 3);
      end
      return r;
   endfunction

   // Level count ceil(log1.5(width/2)) + 1. Levels that see fewer than three
   // rows pass them through, so an over-count is harmless; the max() only
   // guards against ever under-counting.
   function automatic int csa_levels(input int width);
      longint p3;
      longint p2;
      int     n;
      int     need;
      p3 = 64'd1;
      p2 = 64'd1;
      n  = 0;
      while ((64'd2 * p3) < (longint'(width) * p2)) begin
         p3 = p3 * 64'd3;
         p2 = p2 * 64'd2;
         n++;
      end
      need = 0;
      while (csa_rows(width, need) > 2) begin
         need++;
      end
      return ((n + 1) > need) ? (n + 1) : need;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wallace_mult_pipe_cla.sv
`default_nettype none
// ============================================================================
// Module      : cla_adder
// Description : N-bit carry-lookahead adder built as a Kogge-Stone parallel
//               prefix over generate/propagate. No carry in; the carry out
//               is not produced because the product is taken modulo 2^N.
// Revision    : 1.1 - widened to generic N for the pipelined multiplier
// ============================================================================
module cla_adder #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum
);

   logic [N-1:0] gen;
   logic [N-1:0] prop;
   logic [N-1:0] grp_p;

   // Prefix combine: after the loop gen[i] is the carry out of bits [i:0].
   // Descending index order keeps the [i-d] operands at their previous-span values.
   always_comb begin
      gen   = a & b;
      prop  = a ^ b;
      grp_p = prop;
      for (int d = 1; d < N; d = d * 2) begin
         for (int i = N - 1; i >= d; i--) begin
            gen[i]   = gen[i] | (grp_p[i] & gen[i-d]);
            grp_p[i] = grp_p[i] & grp_p[i-d];
         end
      end
      sum = prop ^ {gen[N-2:0], 1'b0};
   end

endmodule
`default_nettype wire

// File: rtl/wallace_mult_pipe_csa_row.sv
`default_nettype none
// ============================================================================
// Module      : csa_row
// Description : N-bit 3:2 carry-save compressor. The carry vector is
//               returned already shifted left by one bit; the carry out of
//               the top bit falls off (all arithmetic is modulo 2^N).
// Revision    : 1.0 - initial release
// ============================================================================
module csa_row #(
   parameter int N = 32
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic [N-1:0] z,
   output logic [N-1:0] sum,
   output logic [N-1:0] carry
);

   assign sum   = x ^ y ^ z;
   assign carry = {((x[N-2:0] & y[N-2:0]) |
                    (x[N-2:0] & z[N-2:0]) |
                    (y[N-2:0] & z[N-2:0])), 1'b0};

endmodule
`default_nettype wire

// File: rtl/wallace_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : wallace_mult_pipe
// Description : Pipelined WIDTH x WIDTH Wallace-tree multiplier with a
//               per-operation signed (Baugh-Wooley) / unsigned mode, an
//               opaque tag, valid/ready handshakes and full backpressure.
//               S1 = operand capture, S2 = first half of CSA tree
//               (MID_REG=1 only), S3 = rest of tree + CLA -> out_prod.
// Revision    : 2.0 - pipelined, parametrised successor of the 16x16 comb unit
// ============================================================================
module wallace_mult_pipe
   import wallace_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int TAG_W   = 4,
   parameter int MID_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod,
   output logic [TAG_W-1:0]     out_tag
);

   localparam int PW     = prod_width(WIDTH);
   localparam int LEVELS = csa_levels(WIDTH);
   localparam int CUT    = LEVELS / 2;

   // Baugh-Wooley correction constant: ones at bit WIDTH and bit 2*WIDTH-1
   localparam logic [PW-1:0] ONE      = PW'(1);
   localparam logic [PW-1:0] BW_CONST = (ONE << WIDTH) | (ONE << (PW - 1));

   // ---------------------------------------------------------------- S1
   logic                s1_valid;
   logic                s1_ready;
   logic [WIDTH-1:0]    s1_a;
   logic [WIDTH-1:0]    s1_b;
   logic                s1_mode;
   logic [TAG_W-1:0]    s1_tag;

   // Handshake into S3 (from S2 or straight from S1 when no mid register)
   logic                feed_valid;
   logic [TAG_W-1:0]    feed_tag;

   // ---------------------------------------------------------------- S3
   logic                s3_valid;
   logic                s3_ready;
   logic [PW-1:0]       prod_q;
   logic [TAG_W-1:0]    tag_q;
   logic [PW-1:0]       final_sum;

   // A stage may load when it is empty or its content leaves this cycle
   assign s3_ready = !s3_valid | out_ready;
   assign in_ready = s1_ready;

   // S1 valid bit: refill whenever the stage can advance
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (s1_ready) begin
         s1_valid <= in_valid;
      end
   end

   // S1 data: capture operands, mode and tag on an input transfer
   always_ff @(posedge clk) begin
      if (s1_ready && in_valid) begin
         s1_a    <= in_a;
         s1_b    <= in_b;
         s1_mode <= in_signed;
         s1_tag  <= in_tag;
      end
   end

   // ------------------------------------------------ partial products
   logic          sgn;
   logic [PW-1:0] pp [0:WIDTH-1];

   assign sgn = (s1_mode == MODE_SIGNED);

   // Row i holds a*b[i] shifted by i; in signed mode the cross terms that
   // involve exactly one operand MSB are inverted.
   for (genvar i = 0; i < WIDTH; i++) begin : g_pp_row
      logic [WIDTH-1:0] bits;
      for (genvar j = 0; j < WIDTH; j++) begin : g_pp_bit
         localparam logic INV = ((i == WIDTH - 1) != (j == WIDTH - 1));
         assign bits[j] = (s1_a[j] & s1_b[i]) ^ (INV & sgn);
      end
      if (i == 0) begin : g_const
         // Row 0 is empty at bits WIDTH and 2*WIDTH-1, so the constant rides here
         assign pp[i] = PW'(bits) | (sgn ? BW_CONST : '0);
      end else begin : g_plain
         assign pp[i] = PW'(bits) << i;
      end
   end

   // -------------------------------------------------------- CSA tree
   // Each level compresses groups of three rows into two; leftovers pass through.
   for (genvar l = 0; l < LEVELS; l++) begin : g_level
      localparam int RI = csa_rows(WIDTH, l);
      localparam int RO = csa_rows(WIDTH, l + 1);
      localparam int NG = RI / 3;

      logic [PW-1:0] rin  [0:RI-1];
      logic [PW-1:0] rout [0:RO-1];

      for (genvar k = 0; k < RI; k++) begin : g_in
         if (l == 0) begin : g_src_pp
            assign rin[k] = pp[k];
         end else if ((MID_REG != 0) && (l == CUT)) begin : g_src_mid
            assign rin[k] = g_mid.g_row[k].q;
         end else begin : g_src_prev
            assign rin[k] = g_level[l-1].rout[k];
         end
      end

      for (genvar g = 0; g < NG; g++) begin : g_csa
         csa_row #(.N(PW)) u_csa (
            .x     (rin[3*g]),
            .y     (rin[3*g+1]),
            .z     (rin[3*g+2]),
            .sum   (rout[2*g]),
            .carry (rout[2*g+1])
         );
      end

      for (genvar k = 0; k < RI - 3 * NG; k++) begin : g_pass
         assign rout[2*NG+k] = rin[3*NG+k];
      end
   end

   // ---------------------------------------------- S2 (mid register)
   if (MID_REG != 0) begin : g_mid
      localparam int RC = csa_rows(WIDTH, CUT);

      logic             s2_valid;
      logic             s2_ready;
      logic             s2_load;
      logic [TAG_W-1:0] s2_tag;

      assign s2_ready   = !s2_valid | s3_ready;
      assign s2_load    = s2_ready & s1_valid;
      assign s1_ready   = !s1_valid | s2_ready;
      assign feed_valid = s2_valid;
      assign feed_tag   = s2_tag;

      // S2 valid bit: take S1's valid whenever S2 can advance
      always_ff @(posedge clk) begin
         if (rst) begin
            s2_valid <= 1'b0;
         end else if (s2_ready) begin
            s2_valid <= s1_valid;
         end
      end

      // S2 tag travels alongside the half-reduced rows
      always_ff @(posedge clk) begin
         if (s2_load) begin
            s2_tag <= s1_tag;
         end
      end

      for (genvar k = 0; k < RC; k++) begin : g_row
         logic [PW-1:0] q;
         // Register one half-reduced row at the tree cut
         always_ff @(posedge clk) begin
            if (s2_load) begin
               q <= g_level[CUT-1].rout[k];
            end
         end
      end
   end else begin : g_nomid
      assign s1_ready   = !s1_valid | s3_ready;
      assign feed_valid = s1_valid;
      assign feed_tag   = s1_tag;
   end

   // ------------------------------------------------ final adder / S3
   // Carry out of the final add is dropped: zero for unsigned, meaningless for signed
   cla_adder #(.N(PW)) u_cla (
      .a   (g_level[LEVELS-1].rout[0]),
      .b   (g_level[LEVELS-1].rout[1]),
      .sum (final_sum)
   );

   // S3 valid bit: cleared by reset, advances when the consumer can take it
   always_ff @(posedge clk) begin
      if (rst) begin
         s3_valid <= 1'b0;
      end else if (s3_ready) begin
         s3_valid <= feed_valid;
      end
   end

   // S3 data: hold while stalled so out_prod/out_tag stay stable
   always_ff @(posedge clk) begin
      if (s3_ready && feed_valid) begin
         prod_q <= final_sum;
         tag_q  <= feed_tag;
      end
   end

   assign out_valid = s3_valid;
   assign out_prod  = s3_valid ? prod_q : '0;
   assign out_tag   = s3_valid ? tag_q  : '0;

endmodule
`default_nettype wire
